prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that writes the instruction image into program memory before the core runs. It accepts a little-endian byte stream on a valid/ready interface, typically from a UART receiver. It assembles 32-bit words and drives the program-memory write port. It holds the core in reset until the whole image is written, then releases it.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first word written.
- MAX_WORDS, 1024: largest image accepted, in words.
- TIMEOUT_CYCLES, 16'd50000: number of consecutive idle cycles mid-load that count as a stall; 0 disables the timeout.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- inData  in  8  byte from the stream source.
- inValid  in  1  inData is valid this cycle.
- inReady  out  1  loader accepts a byte this cycle; transfer = inValid && inReady.
- memWrite  out  1  one-cycle program-memory write strobe.
- memAddr  out  32  word-aligned write byte address.
- memData  out  32  write data, little-endian assembled.
- coreNReset  out  1  active-low reset to the core; low while loading.
- done  out  1  image loaded, core released.
- error  out  1  load aborted (oversize or timeout).

## Operation
- Stream format: 4-byte word count N (LSB first), then N words of 4 bytes each, LSB first.
- States:
  - HEADER: collect 4 count bytes. On the 4th byte:
    - N == 0 -> DONE.
    - N > MAX_WORDS -> ERROR.
    - otherwise -> DATA.
  - DATA: collect 4 bytes into memData. The byte with lane counter k goes to memData[8k+7:8k]. On the 4th byte -> WRITE.
  - WRITE: single cycle.
    - memWrite = 1, memAddr = BASE_ADDR + 4*wordIdx.
    - wordIdx increments at the end of the cycle.
    - If the incremented wordIdx equals N -> DONE, else -> DATA.
  - DONE: terminal. coreNReset = 1, done = 1.
  - ERROR: terminal. coreNReset = 0, error = 1. Only nReset leaves this state.
- inReady = 1 only in HEADER and DATA while nReset is high. It is 0 in WRITE, DONE and ERROR.
- Bytes offered while inReady = 0 are not consumed. The source must hold them.
- Counters:
  - 2-bit lane counter, wraps 3 -> 0.
  - wordIdx is wide enough for MAX_WORDS; N is held in a 32-bit register.
  - memAddr arithmetic is modulo 2^32.
- Timeout:
  - The idle counter runs in HEADER and DATA only after at least one byte of the stream has been accepted.
  - It clears on every transfer.
  - When it reaches TIMEOUT_CYCLES, the state goes to ERROR on the next edge.
  - A source that has sent nothing waits in HEADER forever.
- Extra bytes after DONE are never accepted.

## Timing
- Reset values (asynchronous, held while nReset is low):
  - state = HEADER.
  - inReady = 0, memWrite = 0, memAddr = BASE_ADDR, memData = 0.
  - coreNReset = 0, done = 0, error = 0.
  - All counters = 0.
- All outputs except inReady are registered or decoded directly from the state register. There are no combinational paths from inData or inValid to any output.
- Write latency: memWrite is asserted on the cycle immediately after the edge that accepted the 4th byte of a word. memAddr and memData are stable during that cycle.
- Peak throughput: one word per 5 cycles (4 transfers plus 1 WRITE).
- Release: coreNReset and done rise on the cycle after the last WRITE cycle. They stay high until nReset.
- Reset mid-load: everything returns to the reset values immediately and the partial image is abandoned. The next stream is parsed from a fresh header.
- Reset deassertion: inReady may rise in the first cycle after nReset goes high.

## Test plan
- **Normal load.** BASE_ADDR = 0. Stream 02 00 00 00, 13 05 10 00, 6F 00 00 00 with inValid held high.
  - Required: writes (0x0, 0x00100513) then (0x4, 0x0000006F), each a 1-cycle memWrite.
  - done and coreNReset rise the cycle after the 2nd write.
- **Empty image.** Header 00 00 00 00.
  - Required: no memWrite; DONE on the cycle after the 4th byte.
  - Further valid bytes see inReady = 0.
- **Oversize.** MAX_WORDS = 4, header 05 00 00 00.
  - Required: error = 1, coreNReset stays 0, no memWrite, inReady = 0 thereafter.
- **Backpressure and gaps.**
  - inValid toggled randomly: the written word must be identical to the gap-free case.
  - A byte presented during WRITE must not be consumed until DATA.
- **Timeout.** TIMEOUT_CYCLES = 8, stall 8 idle cycles after the 2nd data byte.
  - Required: error = 1 on the following edge.
  - A stall of 7 cycles then resume completes normally.
- **Reset mid-load.** Assert nReset after 1 of 3 words is written, then resend a full 1-word image.
  - Required: outputs show reset values asynchronously.
  - The new image is written at BASE_ADDR and done is asserted.

Source files
------------

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prog_loader                                                  |
// | Description : Boot-time program loader. Parses a little-endian byte        |
// |               stream (word count, then words), writes each word into       |
// |               program memory and releases the core once the image is in.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prog_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 1024,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [7:0]  inData,
  input  logic        inValid,
  output logic        inReady,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [31:0] memData,
  output logic        coreNReset,
  output logic        done,
  output logic        error
);

  // Word index must be able to hold MAX_WORDS itself (the post-increment value).
  localparam int          c_IDX_W = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] c_MAX   = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_HEADER = 3'd0,
    S_DATA   = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t               r_state;
  logic [1:0]           r_lane;
  logic [31:0]          r_count;
  logic [c_IDX_W-1:0]   r_wordIdx;
  logic [15:0]          r_idle;
  logic                 r_started;

  logic                 w_xfer;
  logic [31:0]          w_hdrCount;
  logic [c_IDX_W-1:0]   w_nextIdx;
  logic                 w_lastWord;
  logic                 w_timeout;

  // Only the byte-collecting states accept data; the reset term keeps inReady low during reset.
  assign inReady    = nReset && ((r_state == S_HEADER) || (r_state == S_DATA));
  assign w_xfer     = inValid && inReady;
  // Full count as it will look once the 4th header byte lands.
  assign w_hdrCount = {inData, r_count[23:0]};
  assign w_nextIdx  = r_wordIdx + {{(c_IDX_W-1){1'b0}}, 1'b1};
  assign w_lastWord = (32'(w_nextIdx) == r_count);
  // A stall is only counted once the stream has started; zero disables it.
  assign w_timeout  = (TIMEOUT_CYCLES != 16'd0) && r_started && (r_idle == TIMEOUT_CYCLES);

  // Load sequencer: state, counters and all registered outputs.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state    <= S_HEADER;
      r_lane     <= 2'd0;
      r_count    <= 32'd0;
      r_wordIdx  <= '0;
      r_idle     <= 16'd0;
      r_started  <= 1'b0;
      memWrite   <= 1'b0;
      memAddr    <= BASE_ADDR;
      memData    <= 32'd0;
      coreNReset <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      memWrite <= 1'b0;
      case (r_state)
        S_HEADER, S_DATA: begin
          if (w_timeout) begin
            r_state <= S_ERROR;
            error   <= 1'b1;
          end else if (w_xfer) begin
            r_idle    <= 16'd0;
            r_started <= 1'b1;
            r_lane    <= r_lane + 2'd1;
            if (r_state == S_HEADER) begin
              r_count[{r_lane, 3'b000} +: 8] <= inData;
              if (r_lane == 2'd3) begin
                if (w_hdrCount == 32'd0) begin
                  r_state    <= S_DONE;
                  done       <= 1'b1;
                  coreNReset <= 1'b1;
                end else if (w_hdrCount > c_MAX) begin
                  r_state <= S_ERROR;
                  error   <= 1'b1;
                end else begin
                  r_state <= S_DATA;
                end
              end
            end else begin
              memData[{r_lane, 3'b000} +: 8] <= inData;
              if (r_lane == 2'd3) begin
                r_state  <= S_WRITE;
                memWrite <= 1'b1;
              end
            end
          end else if (r_started && (TIMEOUT_CYCLES != 16'd0)) begin
            r_idle <= r_idle + 16'd1;
          end
        end
        S_WRITE: begin
          r_wordIdx <= w_nextIdx;
          memAddr   <= memAddr + 32'd4;
          if (w_lastWord) begin
            r_state    <= S_DONE;
            done       <= 1'b1;
            coreNReset <= 1'b1;
          end else begin
            r_state <= S_DATA;
          end
        end
        default: begin
          // DONE and ERROR are terminal; only nReset leaves them.
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_prog_loader                                               |
// | Description : Self-checking bench for prog_loader with a stream-level      |
// |               reference model and directed plus randomized loads.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 4;
  localparam logic [15:0] TMO  = 16'd8;

  logic        clk     = 1'b0;
  logic        nReset  = 1'b1;
  logic [7:0]  inData  = 8'h00;
  logic        inValid = 1'b0;
  logic        inReady;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        coreNReset;
  logic        done;
  logic        error;

  prog_loader #(
    .BASE_ADDR     (BASE),
    .MAX_WORDS     (MAXW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clock     (clk),
    .nReset    (nReset),
    .inData    (inData),
    .inValid   (inValid),
    .inReady   (inReady),
    .memWrite  (memWrite),
    .memAddr   (memAddr),
    .memData   (memData),
    .coreNReset(coreNReset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // ---------------- stream-level reference model ----------------
  int          mBytes   = 0;      // bytes accepted in the current stream
  logic [31:0] mN       = 32'd0;  // word count from header
  logic [31:0] mWord    = 32'd0;  // word under assembly
  logic [31:0] mWritten = 32'd0;  // words already written
  logic        mWr      = 1'b0;   // a write is due this cycle
  logic        mDone    = 1'b0;
  logic        mErr     = 1'b0;
  logic        mStarted = 1'b0;
  int          mIdle    = 0;
  logic [31:0] mWrAddr  = 32'd0;
  logic [31:0] mWrData  = 32'd0;
  logic [63:0] mLog[$];

  initial forever begin
    int k;
    @(posedge clk or negedge nReset);
    if (!nReset) begin
      mBytes = 0; mN = 0; mWord = 0; mWritten = 0; mWr = 0;
      mDone = 0; mErr = 0; mStarted = 0; mIdle = 0;
    end else if (mDone || mErr) begin
      // terminal until reset
    end else if (mWr) begin
      mWr      = 1'b0;
      mWritten = mWritten + 32'd1;
      if (mWritten == mN) mDone = 1'b1;
    end else if (mStarted && (TMO != 16'd0) && (mIdle == int'(TMO))) begin
      mErr = 1'b1;
    end else if (inValid) begin
      mIdle    = 0;
      mStarted = 1'b1;
      if (mBytes < 4) begin
        mN[8*mBytes +: 8] = inData;
        mBytes++;
        if (mBytes == 4) begin
          if (mN == 32'd0) mDone = 1'b1;
          else if (mN > 32'(MAXW)) mErr = 1'b1;
        end
      end else begin
        k = (mBytes - 4) % 4;
        mWord[8*k +: 8] = inData;
        mBytes++;
        if (k == 3) begin
          mWr     = 1'b1;
          mWrAddr = BASE + 32'd4 * mWritten;
          mWrData = mWord;
          mLog.push_back({mWrAddr, mWord});
        end
      end
    end else if (mStarted) begin
      mIdle++;
    end
  end

  // ---------------- per-cycle comparison ----------------
  int cyc     = 0;
  int doneCyc = 0;
  logic prevDone = 1'b0;
  int wrCycles[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    check1("inReady", inReady, nReset && !mDone && !mErr && !mWr);
    check1("memWrite", memWrite, mWr);
    check1("done", done, mDone);
    check1("coreNReset", coreNReset, mDone);
    check1("error", error, mErr);
    if (mWr) begin
      check("memAddr", memAddr, mWrAddr);
      check("memData", memData, mWrData);
    end
    if (!nReset) begin
      check("memAddr in reset", memAddr, BASE);
      check("memData in reset", memData, 32'd0);
    end
    if (memWrite) wrCycles.push_back(cyc);
    if (done && !prevDone) doneCyc = cyc;
    prevDone = done;
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] img[8];

  task automatic checkResetValues();
    check1("rst inReady", inReady, 1'b0);
    check1("rst memWrite", memWrite, 1'b0);
    check1("rst done", done, 1'b0);
    check1("rst error", error, 1'b0);
    check1("rst coreNReset", coreNReset, 1'b0);
    check("rst memAddr", memAddr, BASE);
    check("rst memData", memData, 32'd0);
  endtask

  // Asserts reset in the middle of a cycle so the asynchronous clear is visible.
  task automatic applyReset();
    @(posedge clk); #3;
    nReset  = 1'b0;
    inValid = 1'b0;
    #1;
    checkResetValues();
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b1;
    mLog.delete();
    wrCycles.delete();
    doneCyc = 0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int   n;
    logic acc;
    n       = 0;
    acc     = 1'b0;
    inData  = b;
    inValid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = inReady;
      @(posedge clk); #1;
      if (!acc && (mDone || mErr)) break;
      n++;
      if (n > 40) begin
        nChecks++;
        $display("FAIL sendByte: byte 0x%02h not accepted within 40 cycles", b);
        break;
      end
    end
    inValid = 1'b0;
  endtask

  task automatic gap(input int maxGap);
    int g;
    if (maxGap <= 0) return;
    g = ($urandom_range(0, 24) == 0) ? 9 : int'($urandom_range(0, maxGap));
    repeat (g) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic sendStream(input logic [31:0] n, input int nw, input int maxGap);
    logic [7:0]  b;
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      if (mDone || mErr) return;
      gap(maxGap);
      b = n[8*i +: 8];
      sendByte(b);
    end
    for (int j = 0; j < nw; j++) begin
      w = img[j];
      for (int i = 0; i < 4; i++) begin
        if (mDone || mErr) return;
        gap(maxGap);
        b = w[8*i +: 8];
        sendByte(b);
      end
    end
  endtask

  task automatic waitEnd(input int bound);
    int n;
    n = 0;
    while (!(mDone || mErr)) begin
      @(posedge clk); #1;
      n++;
      if (n > bound) begin
        nChecks++;
        $display("FAIL waitEnd: load did not finish within %0d cycles", bound);
        return;
      end
    end
  endtask

  task automatic offer(input logic [7:0] b, input int n);
    inData  = b;
    inValid = 1'b1;
    idle(n);
    inValid = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] n;
    int          r;
    #2;
    nReset = 1'b0;
    #1;
    checkResetValues();
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b1;

    // Normal load, gap-free.
    applyReset();
    img[0] = 32'h0010_0513;
    img[1] = 32'h0000_006F;
    sendStream(32'd2, 2, 0);
    waitEnd(50);
    idle(2);
    check("normal log size", 32'(mLog.size()), 32'd2);
    if (mLog.size() == 2) begin
      check("normal write0 addr", mLog[0][63:32], 32'h0000_0000);
      check("normal write0 data", mLog[0][31:0], 32'h0010_0513);
      check("normal write1 addr", mLog[1][63:32], 32'h0000_0004);
      check("normal write1 data", mLog[1][31:0], 32'h0000_006F);
    end
    check("normal dut write count", 32'(wrCycles.size()), 32'd2);
    if (wrCycles.size() == 2) begin
      check("write spacing", 32'(wrCycles[1] - wrCycles[0]), 32'd5);
      check("done after last write", 32'(doneCyc - wrCycles[1]), 32'd1);
    end
    check1("normal done", done, 1'b1);
    check1("normal coreNReset", coreNReset, 1'b1);

    // Empty image.
    applyReset();
    sendStream(32'd0, 0, 0);
    idle(1);
    check1("empty done", done, 1'b1);
    offer(8'hAA, 3);
    check1("empty inReady after done", inReady, 1'b0);
    check("empty dut write count", 32'(wrCycles.size()), 32'd0);

    // Oversize header.
    applyReset();
    img[0] = 32'h1234_5678;
    sendStream(32'd5, 1, 0);
    idle(1);
    check1("oversize error", error, 1'b1);
    check1("oversize coreNReset", coreNReset, 1'b0);
    offer(8'h55, 3);
    check1("oversize inReady", inReady, 1'b0);
    check("oversize dut write count", 32'(wrCycles.size()), 32'd0);

    // Timeout: 8 idle cycles after the 2nd data byte.
    applyReset();
    sendByte(8'h01); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
    sendByte(8'h11); sendByte(8'h22);
    idle(8);
    check1("timeout not yet", error, 1'b0);
    idle(1);
    check1("timeout error", error, 1'b1);

    // A 7-cycle stall resumes normally.
    applyReset();
    sendByte(8'h01); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
    sendByte(8'h11); sendByte(8'h22);
    idle(7);
    sendByte(8'h33); sendByte(8'h44);
    waitEnd(20);
    check1("stall7 done", done, 1'b1);
    check1("stall7 no error", error, 1'b0);
    if (mLog.size() == 1) check("stall7 data", mLog[0][31:0], 32'h4433_2211);
    else check("stall7 log size", 32'(mLog.size()), 32'd1);

    // Reset mid-load, then a fresh 1-word image.
    applyReset();
    sendByte(8'h03); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
    sendByte(8'hA1); sendByte(8'hB2); sendByte(8'hC3); sendByte(8'hD4);
    sendByte(8'hE5); sendByte(8'hF6);
    check("midload log size", 32'(mLog.size()), 32'd1);
    applyReset();
    img[0] = 32'hCAFE_F00D;
    sendStream(32'd1, 1, 0);
    waitEnd(30);
    check1("reload done", done, 1'b1);
    if (mLog.size() == 1) begin
      check("reload addr", mLog[0][63:32], BASE);
      check("reload data", mLog[0][31:0], 32'hCAFE_F00D);
    end else begin
      check("reload log size", 32'(mLog.size()), 32'd1);
    end

    // Randomized loads with random gaps, occasional stalls and oversize headers.
    for (int t = 0; t < 40; t++) begin
      applyReset();
      r = int'($urandom_range(0, 9));
      if (r == 0)      n = 32'd0;
      else if (r == 1) n = (r == 1 && $urandom_range(0, 1) == 1) ? $urandom() | 32'h0000_0100 : 32'd5;
      else             n = 32'($urandom_range(1, MAXW));
      for (int j = 0; j < MAXW; j++) img[j] = $urandom();
      sendStream(n, (n > 32'(MAXW)) ? 1 : int'(n), int'($urandom_range(0, 3)));
      waitEnd(300);
      idle(2);
    end

    idle(3);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
